// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: sequencer state encoding, instruction constants
// and the PC alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_seq_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] PC_STEP     = 32'd4;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, redirect and decode handshake signals of the fetch sequencer.
interface fetch_sequencer_if;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    modport master (
        output mem_re, mem_addr, instr_valid, instr_out, instr_pc,
        input  mem_rvalid, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_re, mem_addr, instr_valid, instr_out, instr_pc,
        output mem_rvalid, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport monitor (
        input mem_re, mem_rvalid
    );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter used for the decode back-pressure statistic.
module fetch_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step on each event, sticking at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/fetch_sequencer_chk.sv
// Protocol checker: one read outstanding at most, and responses only when owed.
module fetch_sequencer_chk (
    input logic                clock,
    input logic                reset,
    fetch_sequencer_if.monitor mon
);
    logic owed_q;

    // Tracks whether a read has been issued and not yet answered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owed_q <= 1'b0;
        end else if (mon.mem_re) begin
            owed_q <= 1'b1;
        end else if (mon.mem_rvalid) begin
            owed_q <= 1'b0;
        end else begin
            owed_q <= owed_q;
        end
    end

    a_single_outstanding: assert property (@(posedge clock) disable iff (reset)
        mon.mem_re |-> !owed_q);

    a_rvalid_only_when_owed: assert property (@(posedge clock) disable iff (reset)
        mon.mem_rvalid |-> owed_q);
endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: one outstanding instruction read, registered hand-off to decode,
// redirects with stale-response draining. FETCH_PERF_EN adds the stall_cycles counter.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);
    fetch_seq_state_e state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      instr_out_q, instr_out_d;
    logic [31:0]      instr_pc_q, instr_pc_d;
    logic             mem_re_s;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("fetch_sequencer: CNT_W must be at least 1");
    end

    // Next-state, PC and decode-register update; redirect overrides every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        mem_re_s      = 1'b0;
        case (state_q)
            FETCH: begin
                mem_re_s = ~reset;
                if (bus.redirect_valid) begin
                    pc_d          = align_pc(bus.redirect_pc);
                    instr_valid_d = 1'b0;
                    state_d       = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d          = align_pc(bus.redirect_pc);
                    instr_valid_d = 1'b0;
                    state_d       = bus.mem_rvalid ? FETCH : DRAIN;
                end else if (bus.mem_rvalid) begin
                    instr_out_d   = bus.mem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + PC_STEP;
                    state_d       = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d          = align_pc(bus.redirect_pc);
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                // The owed response belongs to an abandoned path and is never delivered.
                if (bus.redirect_valid) begin
                    pc_d          = align_pc(bus.redirect_pc);
                    instr_valid_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
                state_d = bus.mem_rvalid ? FETCH : DRAIN;
            end
            default: begin
                state_d       = FETCH;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State, PC and decode output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_out_q   <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign bus.mem_re      = mem_re_s;
    assign bus.mem_addr    = align_pc(pc_q);
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .inc_i   (instr_valid_q & ~bus.instr_ready),
        .count_o (stall_cycles)
    );
`endif
endmodule
